// File: rtl/dm_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dm_stream_reader
// Purpose  : Reads a contiguous (or strided) block of data-memory words and
//            streams them out over a valid/ready interface through a
//            two-entry skid buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle transfer request (honoured only when idle)
//   base_addr   first word address, sampled with start
//   len         word count, sampled with start (0 = empty transfer)
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle completion pulse
//   dm_addr     data-memory word address
//   dm_re       data-memory read enable
//   dm_we       data-memory write enable, tied low
//   dm_rd_data  data-memory read data, valid the cycle after dm_re
//   out_data    streamed word (head of the buffer)
//   out_valid   out_data holds a valid word
//   out_ready   consumer accepts the word when high together with out_valid
//   stride      address increment, sampled with start (only with the macro)
// Configuration
//   DM_RDR_STRIDE_EN  when defined, adds the stride input; otherwise the
//                     address advances by 1 per read.
// ============================================================================
module dm_stream_reader #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_re,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef DM_RDR_STRIDE_EN
   ,
   input  logic [ADDR_W-1:0] stride
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [LEN_W-1:0]  remaining;
   logic              in_flight;   // a read was issued last cycle; data lands this cycle
   logic [1:0]        count;       // buffer occupancy, 0..2
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] step;

   logic pop;
   logic push;
   logic issue;
   logic drain_done;

`ifdef DM_RDR_STRIDE_EN
   logic [ADDR_W-1:0] stride_r;
   assign step = stride_r;
`else
   assign step = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

   assign pop  = (count != 2'd0) && out_ready;
   assign push = in_flight;

   // Issue only when the word would still have a buffer slot once it lands:
   // count + in_flight - pop < 2, rearranged to avoid underflow.
   assign issue = (state == ST_RUN) &&
                  (({1'b0, count} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));

   assign drain_done = (state == ST_DRAIN) && !in_flight && (count == 2'd0);

   assign busy      = (state != ST_IDLE);
   assign done      = drain_done;
   assign dm_addr   = addr_r;
   assign dm_re     = issue;
   assign dm_we     = 1'b0;
   assign out_data  = head;
   assign out_valid = (count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         in_flight <= 1'b0;
         count     <= 2'd0;
         head      <= '0;
         tail      <= '0;
         addr_r    <= '0;
`ifdef DM_RDR_STRIDE_EN
         stride_r  <= '0;
`endif
      end else begin
         in_flight <= issue;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_r    <= base_addr;
                  remaining <= len;
`ifdef DM_RDR_STRIDE_EN
                  stride_r  <= stride;
`endif
                  state     <= (len == '0) ? ST_DRAIN : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  addr_r    <= addr_r + step;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Two-entry buffer: head is presented on out_data, tail backs it up.
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= dm_rd_data;
               else               tail <= dm_rd_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= dm_rd_data;
               end else begin
                  head <= tail;
                  tail <= dm_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dm_stream_reader
// Purpose  : Scoreboard bench for dm_stream_reader. Expected read addresses
//            and streamed words are queued when a transfer is launched; a
//            monitor pops and compares on every dm_re and every handshake.
// Revision : 1.0 - initial release
// Configuration
//   DM_RDR_STRIDE_EN  when defined, also drives the stride port and runs the
//                     strided transfer.
// ============================================================================
module tb_dm_stream_reader;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy, done, dm_re, dm_we, out_valid;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_rd_data = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b1;
`ifdef DM_RDR_STRIDE_EN
   logic [ADDR_W-1:0] stride = 13'd1;
`endif

   dm_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .dm_addr    (dm_addr),
      .dm_re      (dm_re),
      .dm_we      (dm_we),
      .dm_rd_data (dm_rd_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
`ifdef DM_RDR_STRIDE_EN
      ,
      .stride     (stride)
`endif
   );

   always #5 clk = ~clk;

   // Data memory: address sampled on posedge with dm_re, data driven on negedge.
   logic [DATA_W-1:0] mem [0:8191];
   logic              rd_pend = 1'b0;
   logic [ADDR_W-1:0] rd_a = '0;
   always @(posedge clk) begin
      rd_pend <= dm_re;
      rd_a    <= dm_addr;
   end
   always @(negedge clk) if (rd_pend) dm_rd_data <= mem[rd_a];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int re_cnt = 0, done_cnt = 0, hs_n = 0, hs_first = 0, hs_last = 0;
   logic [ADDR_W-1:0] addr_q [$];
   logic [DATA_W-1:0] data_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: event with nothing expected", name);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         check("dm_we_low", {31'd0, dm_we}, 32'd0);
         if (dm_re) begin
            re_cnt++;
            if (addr_q.size() == 0) fail("dm_addr_extra");
            else check("dm_addr", {19'd0, dm_addr}, {19'd0, addr_q.pop_front()});
         end
         if (out_valid && out_ready) begin
            if (hs_n == 0) hs_first = cyc;
            hs_last = cyc;
            hs_n++;
            if (data_q.size() == 0) fail("out_data_extra");
            else check("out_data", out_data, data_q.pop_front());
         end
         if (done) done_cnt++;
      end
   end

   task automatic clear_counts();
      re_cnt = 0; done_cnt = 0; hs_n = 0; hs_first = 0; hs_last = 0;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == 0) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no done, expected done within 200 cycles", name);
      end
      @(posedge clk); #1;
      check({name, "_addr_left"}, addr_q.size(), 32'd0);
      check({name, "_data_left"}, data_q.size(), 32'd0);
   endtask

   task automatic run_basic(input string name);
      out_ready = 1'b1;
      clear_counts();
      addr_q = '{13'h010, 13'h011, 13'h012, 13'h013};
      data_q = '{32'h110, 32'h111, 32'h112, 32'h113};
      do_start(13'h010, 12'd4);
      check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
      wait_done(name);
      check({name, "_re_cycles"}, re_cnt, 32'd4);
      check({name, "_done_cnt"}, done_cnt, 32'd1);
      check({name, "_words"}, hs_n, 32'd4);
      check({name, "_back_to_back"}, hs_last - hs_first, 32'd3);
   endtask

   initial begin
      for (int k = 0; k < 8192; k++) mem[k] = k + 32'h100;

      // Reset state
      repeat (2) @(posedge clk); #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dm_re", {31'd0, dm_re}, 32'd0);
      check("rst_dm_we", {31'd0, dm_we}, 32'd0);
      check("rst_dm_addr", {19'd0, dm_addr}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      rst_n = 1'b1;

      // Basic 4-word transfer, consumer always ready
      run_basic("basic");

      // Stalled consumer for 10 cycles
      out_ready = 1'b0;
      clear_counts();
      addr_q = '{13'h010, 13'h011, 13'h012, 13'h013};
      data_q = '{32'h110, 32'h111, 32'h112, 32'h113};
      do_start(13'h010, 12'd4);
      repeat (10) @(posedge clk);
      #1;
      check("stall_reads_le2", {31'd0, (re_cnt <= 2)}, 32'd1);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_head", out_data, 32'h110);
      out_ready = 1'b1;
      wait_done("stall");
      check("stall_re_cycles", re_cnt, 32'd4);
      check("stall_done_cnt", done_cnt, 32'd1);

      // Address wrap, plus a start pulse while busy that must be ignored
      clear_counts();
      addr_q = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
      data_q = '{32'h20FE, 32'h20FF, 32'h100, 32'h101};
      do_start(13'h1FFE, 12'd4);
      start = 1'b1; base_addr = 13'h0500; len = 12'd2;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("wrap");
      check("wrap_re_cycles", re_cnt, 32'd4);
      check("wrap_done_cnt", done_cnt, 32'd1);

      // Zero-length transfer
      clear_counts();
      do_start(13'h0AA, 12'd0);
      check("len0_done_pulse", {31'd0, done}, 32'd1);
      check("len0_busy", {31'd0, busy}, 32'd1);
      check("len0_no_re", {31'd0, dm_re}, 32'd0);
      @(posedge clk); #1;
      check("len0_done_fall", {31'd0, done}, 32'd0);
      check("len0_busy_fall", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("len0_re_cnt", re_cnt, 32'd0);
      check("len0_words", hs_n, 32'd0);
      check("len0_done_cnt", done_cnt, 32'd1);

      // Reset in the middle of an 8-word transfer
      clear_counts();
      for (int k = 0; k < 8; k++) begin
         addr_q.push_back(13'h040 + 13'(k));
         data_q.push_back(32'h140 + k);
      end
      do_start(13'h040, 12'd8);
      begin
         int n = 0;
         while (hs_n < 2 && n < 50) begin
            @(posedge clk);
            n++;
         end
         if (hs_n < 2) begin
            total++; bad++;
            $display("FAIL abort_wait: got %0d words, expected 2", hs_n);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_dm_re", {31'd0, dm_re}, 32'd0);
      check("abort_dm_addr", {19'd0, dm_addr}, 32'd0);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_out_data", out_data, 32'd0);
      addr_q.delete();
      data_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, 32'd0);
      run_basic("after_abort");

`ifdef DM_RDR_STRIDE_EN
      // Strided transfer
      clear_counts();
      stride = 13'd3;
      addr_q = '{13'h020, 13'h023, 13'h026};
      data_q = '{32'h120, 32'h123, 32'h126};
      do_start(13'h020, 12'd3);
      wait_done("stride");
      check("stride_re_cycles", re_cnt, 32'd3);
      check("stride_done_cnt", done_cnt, 32'd1);
      stride = 13'd1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/dm_stream_reader.md
DM_STREAM_READER -- requirements
Module: dm_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the data-memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data-memory word width.
REQ-003 The block SHALL have parameter LEN_W, default 12, meaning the transfer-length counter width.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 The block SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-008 The block SHALL have port len  input  LEN_W  word count, sampled with start.
REQ-009 The block SHALL have port busy  output  1  high from accepted start until done.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-011 The block SHALL have port dm_addr  output  ADDR_W  data-memory address.
REQ-012 The block SHALL have port dm_re  output  1  data-memory read enable.
REQ-013 The block SHALL have port dm_we  output  1  data-memory write enable, constant 0.
REQ-014 The block SHALL have port dm_rd_data  input  DATA_W  data-memory read data.
REQ-015 The block SHALL have port out_data  output  DATA_W  streamed word.
REQ-016 The block SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-017 The block SHALL have port out_ready  input  1  consumer accepts word when high with out_valid.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN; start is honoured only in IDLE and ignored otherwise.
REQ-019 IDLE->RUN on start with len!=0; IDLE->DRAIN on start with len==0; RUN->DRAIN after the len-th read is issued; DRAIN->IDLE when no read is in flight and the buffer is empty, pulsing done in that cycle.
REQ-020 A read issued (dm_re=1) in cycle N SHALL have dm_rd_data captured at posedge ending cycle N+1 (memory updates data on negedge).
REQ-021 Reads SHALL be issued back-to-back only while (buffer count + in-flight - pop this cycle) < 2; buffer depth SHALL be exactly 2.
REQ-022 out_valid SHALL remain asserted and out_data stable until out_ready is high; word order SHALL equal address order.
REQ-023 dm_addr SHALL advance by the stride per issued read, modulo 2^ADDR_W (0x1FFF wraps to 0x0000).
REQ-024 dm_re SHALL be 0 in IDLE and DRAIN; dm_we SHALL never be 1.
REQ-025 len==0 SHALL issue no reads, assert no out_valid, and pulse done exactly one cycle after start.
REQ-026 busy SHALL rise the cycle after an accepted start and fall in the cycle done pulses.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, dm_re=0, dm_addr=0, busy=0, done=0, out_valid=0, out_data=0, and empty the buffer, including mid-transfer; no done pulse for an aborted transfer.

Configuration
REQ-028 With macro DM_RDR_STRIDE_EN defined, an input stride (ADDR_W bits) SHALL exist, sampled with start, and addresses SHALL advance by stride (stride 0 re-reads base_addr len times).
REQ-029 Without DM_RDR_STRIDE_EN, the stride port SHALL be absent and the stride SHALL be fixed at 1.

Verification
REQ-030 Memory preloaded mem[k]=k+0x100; start, base 0x010, len 4, out_ready=1 -> outputs 0x110,0x111,0x112,0x113 on consecutive cycles, done once, dm_re high 4 cycles.
REQ-031 Same transfer, out_ready held low 10 cycles then high -> at most 2 reads issued while stalled, no word lost or duplicated, order preserved.
REQ-032 base 0x1FFE, len 4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001.
REQ-033 len 0 -> no dm_re, no out_valid, done one cycle after start; start pulsed while busy -> ignored.
REQ-034 rst_n low after 2 of 8 words delivered -> all outputs zero asynchronously, no done; new start after release behaves per REQ-030.
REQ-035 With DM_RDR_STRIDE_EN, base 0x020, stride 3, len 3 -> addresses 0x020,0x023,0x026.
